// File: rtl/truth_sweep_checker.sv
// Clocked exhaustive sweep of the shared x/y/z minterm inputs; compares each
// unit's reduced output against its control output and reports pass/fail.
module truth_sweep_checker #(
  parameter int NFUNC  = 5,
  parameter int SETTLE = 1,
  parameter int CW     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             x,
  output logic             y,
  output logic             z,
  input  logic [NFUNC-1:0] s_in,
  input  logic [NFUNC-1:0] ctrl_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [NFUNC-1:0] fail_mask,
  output logic [CW-1:0]    err_count,
  output logic [2:0]       first_fail_idx,
  output logic             first_fail_valid
);

  localparam int WCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PCW = $clog2(NFUNC + 1);
  localparam logic [WCW-1:0] WRELOAD = WCW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [2:0]       idx_q;
  logic [WCW-1:0]   wcnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [NFUNC-1:0] fail_mask_q;
  logic [CW-1:0]    err_count_q;
  logic [2:0]       ffi_q;
  logic             ffv_q;

  logic [NFUNC-1:0] mm_d;
  logic [NFUNC-1:0] fail_mask_d;
  logic [CW-1:0]    err_count_d;

  function automatic logic [PCW-1:0] popcount(input logic [NFUNC-1:0] v);
    logic [PCW-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < NFUNC; k++) begin
      cnt = cnt + PCW'(v[k]);
    end
    return cnt;
  endfunction

  // One extra bit of headroom detects overflow; clamp to all-ones.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0]  a,
                                            input logic [PCW-1:0] b);
    logic [CW:0] sum;
    sum = {1'b0, a} + (CW+1)'(b);
    return sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
  endfunction

  always_comb begin
    mm_d        = s_in ^ ctrl_in;
    fail_mask_d = fail_mask_q | mm_d;
    err_count_d = sat_add(err_count_q, popcount(mm_d));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wcnt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
      err_count_q <= '0;
      ffi_q       <= '0;
      ffv_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            idx_q       <= '0;
            wcnt_q      <= WRELOAD;
            fail_mask_q <= '0;
            err_count_q <= '0;
            ffi_q       <= '0;
            ffv_q       <= 1'b0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (wcnt_q == '0) begin
            state_q <= CHECK;
          end else begin
            wcnt_q <= wcnt_q - 1'b1;
          end
        end
        CHECK: begin
          fail_mask_q <= fail_mask_d;
          err_count_q <= err_count_d;
          if ((mm_d != '0) && !ffv_q) begin
            ffi_q <= idx_q;
            ffv_q <= 1'b1;
          end
          // idx stays at 7 after the last minterm; only a new start rewinds it.
          if (idx_q == 3'd7) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 3'd1;
            wcnt_q  <= WRELOAD;
            state_q <= WAIT;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          pass_q  <= (fail_mask_q == '0);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {x, y, z}        = idx_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_mask        = fail_mask_q;
  assign err_count        = err_count_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_truth_sweep_checker.sv
// Scoreboard bench for truth_sweep_checker: two instances (SETTLE=1 driven by
// a mode-selected fault injector, SETTLE=3 fed by five equivalent unit pairs).
module tb_truth_sweep_checker;

  typedef struct {
    int         done_cyc;
    logic [4:0] mask;
    logic [5:0] err;
    logic [2:0] ffi;
    logic       ffv;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start3;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  // Instance 1
  logic       x1, y1, z1, busy1, done1, pass1, ffv1;
  logic [4:0] s1, ctrl1, mask1;
  logic [5:0] err1;
  logic [2:0] ffi1;
  logic [1:0] mode;

  // Instance 3
  logic       x3, y3, z3, busy3, done3, pass3, ffv3;
  logic [4:0] s3, ctrl3, mask3;
  logic [5:0] err3;
  logic [2:0] ffi3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  truth_sweep_checker #(.NFUNC(5), .SETTLE(1), .CW(6)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x(x1), .y(y1), .z(z1), .s_in(s1), .ctrl_in(ctrl1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1),
    .err_count(err1), .first_fail_idx(ffi1), .first_fail_valid(ffv1)
  );

  truth_sweep_checker #(.NFUNC(5), .SETTLE(3), .CW(6)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .x(x3), .y(y3), .z(z3), .s_in(s3), .ctrl_in(ctrl3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_mask(mask3),
    .err_count(err3), .first_fail_idx(ffi3), .first_fail_valid(ffv3)
  );

  always_comb begin
    s1 = ctrl1;
    case (mode)
      2'd1: s1 = ctrl1 ^ (({x1, y1, z1} == 3'd5) ? 5'b00100 : 5'b00000);
      2'd2: s1 = ~ctrl1;
      default: s1 = ctrl1;
    endcase
  end

  // Canonical SOP control forms and their hand-reduced equivalents.
  assign ctrl3[0] = (~x3 & ~y3 & z3) | (~x3 & y3 & z3) | (x3 & y3 & z3);
  assign s3[0]    = (~x3 & z3) | (y3 & z3);
  assign ctrl3[1] = (x3 & ~y3 & ~z3) | (x3 & ~y3 & z3);
  assign s3[1]    = x3 & ~y3;
  assign ctrl3[2] = (x3 & ~y3) | (~x3 & y3);
  assign s3[2]    = x3 ^ y3;
  assign ctrl3[3] = ~(x3 & y3 & z3);
  assign s3[3]    = ~x3 | ~y3 | ~z3;
  assign ctrl3[4] = (~x3 & ~y3 & ~z3) | (~x3 & ~y3 & z3) | (x3 & ~y3 & ~z3) | (x3 & ~y3 & z3);
  assign s3[4]    = ~y3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push1(input int dc, input logic [4:0] m, input logic [5:0] e,
                       input logic [2:0] fi, input logic fv, input logic p);
    exp_t t;
    t.done_cyc = dc; t.mask = m; t.err = e; t.ffi = fi; t.ffv = fv; t.pass = p;
    q1.push_back(t);
  endtask

  task automatic push3(input int dc, input logic [4:0] m, input logic [5:0] e,
                       input logic [2:0] fi, input logic fv, input logic p);
    exp_t t;
    t.done_cyc = dc; t.mask = m; t.err = e; t.ffi = fi; t.ffv = fv; t.pass = p;
    q3.push_back(t);
  endtask

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_done actual=done@%0d expected=no done", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_done_cycle", cyc, e1.done_cyc);
        chk("dut1_fail_mask", 32'(mask1), 32'(e1.mask));
        chk("dut1_err_count", 32'(err1), 32'(e1.err));
        chk("dut1_first_fail_idx", 32'(ffi1), 32'(e1.ffi));
        chk("dut1_first_fail_valid", 32'(ffv1), 32'(e1.ffv));
        chk("dut1_pass", 32'(pass1), 32'(e1.pass));
        chk("dut1_busy_at_done", 32'(busy1), 32'd0);
        chk("dut1_xyz_at_done", 32'({x1, y1, z1}), 32'd7);
      end
    end
  end

  always @(negedge clk) begin
    if (done3 === 1'b1) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut3_unexpected_done actual=done@%0d expected=no done", cyc);
      end else begin
        e3 = q3.pop_front();
        chk("dut3_done_cycle", cyc, e3.done_cyc);
        chk("dut3_fail_mask", 32'(mask3), 32'(e3.mask));
        chk("dut3_err_count", 32'(err3), 32'(e3.err));
        chk("dut3_first_fail_valid", 32'(ffv3), 32'(e3.ffv));
        chk("dut3_pass", 32'(pass3), 32'(e3.pass));
      end
    end
  end

  // Start is driven at a negedge; the accepting edge is the next posedge,
  // so done for SETTLE=1 appears 1+17 edges later.
  task automatic sweep1(input logic [4:0] m, input logic [5:0] e,
                        input logic [2:0] fi, input logic fv, input logic p);
    start = 1'b1;
    push1(cyc + 18, m, e, fi, fv, p);
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
  endtask

  initial begin
    int j;
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0; mode = 2'd0; ctrl1 = 5'b10110;
    repeat (3) @(negedge clk);
    chk("dut1_reset_outputs",
        32'({x1, y1, z1, busy1, done1, pass1, mask1, err1, ffi1, ffv1}), 32'd0);
    chk("dut3_reset_outputs",
        32'({x3, y3, z3, busy3, done3, pass3, mask3, err3, ffi3, ffv3}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean sweep with minterm stepping visible on x/y/z
    start = 1'b1;
    push1(cyc + 18, 5'h00, 6'd0, 3'd0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        chk("busy_after_start", 32'(busy1), 32'd1);
      end
      chk("xyz_step", 32'({x1, y1, z1}), 32'(k / 2));
    end
    repeat (6) @(negedge clk);
    chk("xyz_hold_after_done", 32'({x1, y1, z1}), 32'd7);

    // Single-unit fault at minterm 5
    mode = 2'd1;
    sweep1(5'b00100, 6'd1, 3'd5, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_fail_mask_idle", 32'(mask1), 32'h04);
    chk("hold_pass_idle", 32'(pass1), 32'd0);

    // Every unit wrong at every minterm
    mode = 2'd2; ctrl1 = 5'b01101;
    sweep1(5'h1F, 6'd40, 3'd0, 1'b1, 1'b0);

    // Extra start pulses mid-sweep are ignored
    mode = 2'd0; ctrl1 = 5'b10110;
    start = 1'b1;
    push1(cyc + 18, 5'h00, 6'd0, 3'd0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = (k == 4 || k == 12);
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_restart_busy", 32'(busy1), 32'd0);

    // Reset mid-sweep at minterm 3
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    j = 0;
    while (({x1, y1, z1} != 3'd3) && j < 20) begin
      @(negedge clk);
      j++;
    end
    chk("reached_minterm3", 32'({x1, y1, z1}), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_outputs_clear",
        32'({x1, y1, z1, busy1, done1, pass1, mask1, err1, ffi1, ffv1}), 32'd0);
    repeat (25) @(negedge clk);
    chk("abort_still_idle", 32'({busy1, done1}), 32'd0);
    sweep1(5'h00, 6'd0, 3'd0, 1'b0, 1'b1);

    // SETTLE=3 instance with equivalent unit pairs
    start3 = 1'b1;
    push3(cyc + 34, 5'h00, 6'd0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    start3 = 1'b0;
    repeat (40) @(negedge clk);

    chk("dut1_pending_expectations", q1.size(), 32'd0);
    chk("dut3_pending_expectations", q3.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_sweep_checker.md
Name: truth_sweep_checker

Overview:
- Sequential harness stage that drives the shared x/y/z inputs of the Guia_06 function units.
- Sweeps all 8 minterms, then samples each unit's reduced output (s) against its control output (control).
- Accumulates per-unit mismatch flags, an error count and the first failing minterm, then reports pass/fail.
- Replaces the hand-written #1 stimulus sequences with a clocked, self-checking sweep.

Parameters:
- NFUNC, 5, number of function units checked in parallel (units a..e).
- SETTLE, 1, clock cycles x/y/z are held stable before sampling (minimum 1).
- CW, 6, width of err_count; must hold 8*NFUNC, and the counter saturates at all-ones.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- x  output  1  minterm bit 2 (MSB) driven to all units.
- y  output  1  minterm bit 1.
- z  output  1  minterm bit 0 (LSB).
- s_in  input  NFUNC  reduced outputs; bit k is from unit k.
- ctrl_in  input  NFUNC  control outputs; bit k is from unit k.
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  one-cycle pulse when the sweep completes.
- pass  output  1  high after a sweep with no mismatch; held until the next start.
- fail_mask  output  NFUNC  bit k is set if unit k mismatched at any minterm.
- err_count  output  CW  total mismatching (unit, minterm) pairs, saturating.
- first_fail_idx  output  3  minterm index of the first mismatch seen.
- first_fail_valid  output  1  first_fail_idx is meaningful.

Behaviour:
- All outputs are registered. Clock and reset behaviour:
  - Single clock.
  - Synchronous, active-low reset: when rst_n=0 at a rising edge of clk, the state becomes IDLE and every output clears to 0, including x=y=z=0.
  - Reset takes priority over every other event, including mid-sweep; an aborted sweep leaves no partial results.
- {x,y,z} always equals the internal 3-bit index idx.
- States are IDLE, WAIT, CHECK and DONE.
- IDLE:
  - On start=1: idx<=0, wcnt<=SETTLE-1, fail_mask<=0, err_count<=0, first_fail_valid<=0, first_fail_idx<=0, pass<=0, busy<=1, go to WAIT.
  - When start=0: hold all outputs, so results from the last sweep stay visible.
- WAIT:
  - If wcnt==0, go to CHECK; otherwise wcnt<=wcnt-1.
  - start is ignored.
- CHECK:
  - Compute mm = s_in ^ ctrl_in; fail_mask <= fail_mask | mm.
  - err_count <= min(err_count + popcount(mm), 2^CW-1).
  - If mm!=0 and first_fail_valid=0: first_fail_idx<=idx and first_fail_valid<=1.
  - If idx==7, go to DONE; otherwise idx<=idx+1, wcnt<=SETTLE-1, go to WAIT.
  - idx wraps 7->0 only through a new start and never rolls over inside a sweep.
- DONE:
  - done<=1 for exactly one cycle, busy<=0.
  - pass <= (final fail_mask==0); this uses the value including minterm 7's check.
  - Return to IDLE, and x/y/z remain at 3'b111.
  - start asserted during DONE is ignored, so a new sweep needs start in IDLE.
- Timing:
  - Each minterm takes SETTLE+1 cycles.
  - done pulses 8*(SETTLE+1)+1 cycles after the edge that accepted start; this is 17 cycles for SETTLE=1.
- Simultaneous events:
  - rst_n=0 together with start: reset wins.
  - start held high continuously: a new sweep begins on the first IDLE cycle after DONE.
- X/Z on s_in or ctrl_in are unspecified, and the bench must not drive them during CHECK.

Test Plan:
- Reset, start pulse, s_in=ctrl_in=5'b10110 constant, SETTLE=1:
  - x,y,z step 000..111, each held 2 cycles.
  - done pulses 17 cycles after start, with pass=1, fail_mask=0, err_count=0, first_fail_valid=0.
- Bench flips unit 2's s_in only while {x,y,z}=101:
  - fail_mask=5'b00100, err_count=1, first_fail_idx=5, first_fail_valid=1, pass=0.
- s_in = ~ctrl_in for all minterms:
  - err_count=40, fail_mask=5'h1F, first_fail_idx=0, pass=0.
- Extra start pulses while busy=1 (minterms 2 and 6):
  - Sweep timing is unchanged, with a single done pulse at cycle 17.
- rst_n=0 for 1 cycle while {x,y,z}=011:
  - Next cycle all outputs are 0, state is IDLE, and done never fires.
  - A subsequent start runs a full clean sweep.
- SETTLE=3 build with 5 unit instances connected:
  - done at cycle 33, and pass=1 iff each unit's reduced form matches its control form.
